// File: rtl/mem_arbiter_nport_pkg.sv
// Shared types and helpers for the N-port memory arbiter.
package mem_arbiter_nport_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WDATA = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int value);
    return (value > 1) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_nport_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module mem_arbiter_nport_rr_picker #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  // Scan from the pointer upward modulo N_PORTS; the first hit wins.
  always_comb begin
    int pos;
    pos         = 0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_PORTS) pos = pos - N_PORTS;
      if (!grant_any_o && req_i[IDX_W'(pos)]) begin
        grant_any_o             = 1'b1;
        grant_oh_o[IDX_W'(pos)] = 1'b1;
        grant_idx_o             = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_nport.sv
// N-port round-robin arbiter in front of a single main-memory interface.
// Writes lock the memory data channel to one port for a full line; read
// responses are routed back by tag, with a per-port cap on reads in flight.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | arbitrating; combinational grant drives the request channel
// ST_WDATA | streaming DATA_BEATS write beats from wport; no new requests
module mem_arbiter_nport
  import mem_arbiter_nport_pkg::*;
#(
  parameter int N_PORTS         = 2,
  parameter int MEM_ADDR_BITS   = 32,
  parameter int MEM_DATA_BITS   = 64,
  parameter int MEM_TAG_BITS    = 4,
  parameter int DATA_BEATS      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [N_PORTS-1:0]                   port_req_valid,
  output logic [N_PORTS-1:0]                   port_req_ready,
  input  logic [N_PORTS-1:0]                   port_req_rw,
  input  logic [N_PORTS*MEM_ADDR_BITS-1:0]     port_req_addr,
  input  logic [N_PORTS-1:0]                   port_req_data_valid,
  output logic [N_PORTS-1:0]                   port_req_data_ready,
  input  logic [N_PORTS*MEM_DATA_BITS-1:0]     port_req_data_bits,
  input  logic [N_PORTS*MEM_DATA_BITS/8-1:0]   port_req_data_mask,
  output logic [N_PORTS-1:0]                   port_resp_valid,
  output logic                                 mem_req_valid,
  output logic                                 mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]             mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]              mem_req_tag,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_data_valid,
  output logic [MEM_DATA_BITS-1:0]             mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0]           mem_req_data_mask,
  input  logic                                 mem_req_data_ready,
  input  logic                                 mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]              mem_resp_tag,
  output logic                                 resp_tag_err
);

  localparam int IDX_W  = cnt_width(N_PORTS);
  localparam int BEAT_W = cnt_width(DATA_BEATS);
  localparam int OUT_W  = clog2(MAX_OUTSTANDING + 1);
  localparam int MASK_W = MEM_DATA_BITS / 8;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);
  localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_PORTS - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  wport_q, wport_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]  outstanding_q [N_PORTS];
  logic [OUT_W-1:0]  outstanding_d [N_PORTS];
  logic [BEAT_W-1:0] resp_cnt_q [N_PORTS];
  logic [BEAT_W-1:0] resp_cnt_d [N_PORTS];
  logic              tag_err_q, tag_err_d;

  logic [N_PORTS-1:0] eligible;
  logic [N_PORTS-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [N_PORTS-1:0] tag_hit;

  // Writes never consume read slots, so only reads are gated by the cap.
  always_comb begin
    eligible = '0;
    tag_hit  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      eligible[i] = port_req_valid[i] & (port_req_rw[i] | (outstanding_q[i] < OUT_MAX));
      tag_hit[i]  = (mem_resp_tag == MEM_TAG_BITS'(i));
    end
  end

  mem_arbiter_nport_rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i       (eligible),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (gnt_oh),
    .grant_idx_o (gnt_idx),
    .grant_any_o (gnt_any)
  );

  assign resp_tag_err = tag_err_q;

  // Request/data channel muxing; every handshake output is held low in reset.
  always_comb begin
    mem_req_valid       = 1'b0;
    mem_req_rw          = 1'b0;
    mem_req_addr        = '0;
    mem_req_tag         = '0;
    port_req_ready      = '0;
    mem_req_data_valid  = 1'b0;
    mem_req_data_bits   = '0;
    mem_req_data_mask   = '0;
    port_req_data_ready = '0;
    port_resp_valid     = '0;
    if (reset_n) begin
      port_resp_valid = mem_resp_valid ? tag_hit : '0;
      if (state_q == ST_IDLE) begin
        mem_req_valid  = gnt_any;
        mem_req_tag    = MEM_TAG_BITS'(gnt_idx);
        port_req_ready = gnt_oh & {N_PORTS{mem_req_ready}};
        for (int i = 0; i < N_PORTS; i++) begin
          if (gnt_oh[i]) begin
            mem_req_rw   = port_req_rw[i];
            mem_req_addr = port_req_addr[i*MEM_ADDR_BITS +: MEM_ADDR_BITS];
          end
        end
      end else begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (wport_q == IDX_W'(i)) begin
            mem_req_data_valid     = port_req_data_valid[i];
            mem_req_data_bits      = port_req_data_bits[i*MEM_DATA_BITS +: MEM_DATA_BITS];
            mem_req_data_mask      = port_req_data_mask[i*MASK_W +: MASK_W];
            port_req_data_ready[i] = mem_req_data_ready;
          end
        end
      end
    end
  end

  // Next-state: grant pointer, write-beat lock, and per-port read bookkeeping.
  always_comb begin
    logic req_fire;
    logic beat_fire;
    logic issue;
    logic retire;
    req_fire   = mem_req_valid & mem_req_ready;
    beat_fire  = mem_req_data_valid & mem_req_data_ready;
    issue      = 1'b0;
    retire     = 1'b0;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wport_d    = wport_q;
    beat_cnt_d = beat_cnt_q;
    tag_err_d  = tag_err_q;

    if (req_fire) begin
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
      if (mem_req_rw) begin
        wport_d    = gnt_idx;
        beat_cnt_d = '0;
        state_d    = ST_WDATA;
      end
    end

    if (beat_fire) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = '0;
        state_d    = ST_IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end

    // Responses that match no port, or a port with nothing in flight, only flag.
    if (mem_resp_valid && (tag_hit == '0)) tag_err_d = 1'b1;

    for (int i = 0; i < N_PORTS; i++) begin
      outstanding_d[i] = outstanding_q[i];
      resp_cnt_d[i]    = resp_cnt_q[i];
      issue            = req_fire & ~mem_req_rw & gnt_oh[i];
      retire           = 1'b0;
      if (mem_resp_valid && tag_hit[i]) begin
        if (outstanding_q[i] == '0) begin
          tag_err_d = 1'b1;
        end else if (resp_cnt_q[i] == LAST_BEAT) begin
          resp_cnt_d[i] = '0;
          retire        = 1'b1;
        end else begin
          resp_cnt_d[i] = resp_cnt_q[i] + BEAT_W'(1);
        end
      end
      if (issue && !retire) outstanding_d[i] = outstanding_q[i] + OUT_W'(1);
      else if (retire && !issue) outstanding_d[i] = outstanding_q[i] - OUT_W'(1);
    end
  end

  // State registers; async reset abandons any write in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      wport_q    <= '0;
      beat_cnt_q <= '0;
      tag_err_q  <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        outstanding_q[i] <= '0;
        resp_cnt_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wport_q    <= wport_d;
      beat_cnt_q <= beat_cnt_d;
      tag_err_q  <= tag_err_d;
      for (int i = 0; i < N_PORTS; i++) begin
        outstanding_q[i] <= outstanding_d[i];
        resp_cnt_q[i]    <= resp_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Bench for mem_arbiter_nport: 3 ports, 4-beat lines, 2 reads in flight.
module tb_mem_arbiter_nport;

  localparam int N  = 3;
  localparam int A  = 16;
  localparam int D  = 32;
  localparam int T  = 3;
  localparam int B  = 4;
  localparam int MO = 2;
  localparam int M  = D / 8;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    port_req_valid;
  logic [N-1:0]    port_req_ready;
  logic [N-1:0]    port_req_rw;
  logic [N*A-1:0]  port_req_addr;
  logic [N-1:0]    port_req_data_valid;
  logic [N-1:0]    port_req_data_ready;
  logic [N*D-1:0]  port_req_data_bits;
  logic [N*M-1:0]  port_req_data_mask;
  logic [N-1:0]    port_resp_valid;
  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [A-1:0]    mem_req_addr;
  logic [T-1:0]    mem_req_tag;
  logic            mem_req_ready;
  logic            mem_req_data_valid;
  logic [D-1:0]    mem_req_data_bits;
  logic [M-1:0]    mem_req_data_mask;
  logic            mem_req_data_ready;
  logic            mem_resp_valid;
  logic [T-1:0]    mem_resp_tag;
  logic            resp_tag_err;

  mem_arbiter_nport #(
    .N_PORTS(N), .MEM_ADDR_BITS(A), .MEM_DATA_BITS(D), .MEM_TAG_BITS(T),
    .DATA_BEATS(B), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .port_req_valid(port_req_valid), .port_req_ready(port_req_ready),
    .port_req_rw(port_req_rw), .port_req_addr(port_req_addr),
    .port_req_data_valid(port_req_data_valid), .port_req_data_ready(port_req_data_ready),
    .port_req_data_bits(port_req_data_bits), .port_req_data_mask(port_req_data_mask),
    .port_resp_valid(port_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_req_data_ready(mem_req_data_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .resp_tag_err(resp_tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_rr = 0;
  int  m_out [N];
  int  m_rcnt [N];
  bit  m_inw = 0;
  int  m_wport = 0;
  int  m_beat = 0;
  bit  m_err = 0;

  // Events seen on the falling edge, applied to the model at the next rising edge.
  bit  f_acc, f_rw, f_beat, f_rv;
  int  f_g;
  int  f_tag;

  // Observation logs of what actually left the DUT, for the literal checks.
  int          grant_tag [$];
  int          grant_cyc [$];
  logic [35:0] beat_log [$];
  int          resp_seen [N];

  bit           e_found;
  int           e_g;
  logic [N-1:0] e_rdy, e_drdy, e_prv;
  logic         e_dv;

  always @(negedge clk) begin
    e_found = 1'b0; e_g = 0; e_rdy = '0; e_drdy = '0; e_prv = '0; e_dv = 1'b0;
    if (reset_n) begin
      if (!m_inw) begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (m_rr + k) % N;
          if (!e_found && port_req_valid[p] && (port_req_rw[p] || m_out[p] < MO)) begin
            e_found = 1'b1;
            e_g = p;
          end
        end
        if (e_found && mem_req_ready) e_rdy[e_g] = 1'b1;
      end else begin
        e_dv = port_req_data_valid[m_wport];
        if (mem_req_data_ready) e_drdy[m_wport] = 1'b1;
      end
      if (mem_resp_valid && mem_resp_tag < N) e_prv[mem_resp_tag] = 1'b1;
    end
    check("mem_req_valid", mem_req_valid, e_found);
    check("port_req_ready", port_req_ready, e_rdy);
    if (e_found) begin
      check("mem_req_tag", mem_req_tag, e_g);
      check("mem_req_rw", mem_req_rw, port_req_rw[e_g]);
      check("mem_req_addr", mem_req_addr, port_req_addr[e_g*A +: A]);
    end
    check("mem_req_data_valid", mem_req_data_valid, e_dv);
    check("port_req_data_ready", port_req_data_ready, e_drdy);
    if (e_dv) begin
      check("mem_req_data_bits", mem_req_data_bits, port_req_data_bits[m_wport*D +: D]);
      check("mem_req_data_mask", mem_req_data_mask, port_req_data_mask[m_wport*M +: M]);
    end
    check("port_resp_valid", port_resp_valid, e_prv);
    check("resp_tag_err", resp_tag_err, reset_n ? m_err : 1'b0);

    f_acc  = reset_n && e_found && mem_req_ready;
    f_g    = e_g;
    f_rw   = port_req_rw[e_g];
    f_beat = reset_n && e_dv && mem_req_data_ready;
    f_rv   = reset_n && mem_resp_valid;
    f_tag  = int'(mem_resp_tag);

    if (mem_req_valid && mem_req_ready) begin
      grant_tag.push_back(int'(mem_req_tag));
      grant_cyc.push_back(cyc);
    end
    if (mem_req_data_valid && mem_req_data_ready) beat_log.push_back({mem_req_data_mask, mem_req_data_bits});
    for (int p = 0; p < N; p++) if (port_resp_valid[p]) resp_seen[p]++;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rr = 0; m_inw = 0; m_wport = 0; m_beat = 0; m_err = 0;
      for (int p = 0; p < N; p++) begin m_out[p] = 0; m_rcnt[p] = 0; end
    end else begin
      if (f_acc) begin
        m_rr = (f_g + 1) % N;
        if (f_rw) begin m_inw = 1; m_wport = f_g; m_beat = 0; end
        else m_out[f_g]++;
      end
      if (f_beat) begin
        m_beat++;
        if (m_beat == B) m_inw = 0;
      end
      if (f_rv) begin
        if (f_tag >= N || m_out[f_tag] == 0) m_err = 1;
        else begin
          m_rcnt[f_tag]++;
          if (m_rcnt[f_tag] == B) begin m_rcnt[f_tag] = 0; m_out[f_tag]--; end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] mask_tab [4] = '{4'hF, 4'h3, 4'hC, 4'h5};
  int last_resp_cyc = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input int p);
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (port_req_valid[p] && port_req_ready[p]) ok = 1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL req_timeout port %0d: no accept within 50 cycles", p); end
  endtask

  task automatic wait_beat(input int p);
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (port_req_data_valid[p] && port_req_data_ready[p]) ok = 1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL beat_timeout port %0d: no beat within 50 cycles", p); end
  endtask

  task automatic set_wbeat(input int p, input int b);
    logic [31:0] v;
    v = 32'hBEEF_0000 + 32'(b);
    port_req_data_bits[p*D +: D] = v;
    port_req_data_mask[p*M +: M] = mask_tab[b];
  endtask

  task automatic send_resp(input int tag, input int nb);
    for (int b = 0; b < nb; b++) begin
      mem_resp_valid = 1'b1;
      mem_resp_tag   = tag[T-1:0];
      last_resp_cyc  = cyc;
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    int gb, bb;
    int rs0, rs1, rs2;
    logic [31:0] bv;
    reset_n = 1'b0;
    port_req_valid = '0; port_req_rw = '0; port_req_addr = '0;
    port_req_data_valid = '0; port_req_data_bits = '0; port_req_data_mask = '0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_tag = '0;

    // Reset: requests present, yet every handshake output must stay low.
    port_req_valid = 3'b111; mem_req_ready = 1'b1;
    #2;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_port_req_ready", port_req_ready, 0);
    check("rst_resp_tag_err", resp_tag_err, 0);
    port_req_valid = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Round robin: all three ports read until each holds MO reads.
    port_req_addr = {16'h3000, 16'h2000, 16'h1000};
    mem_req_data_ready = 1'b1;
    gb = grant_tag.size();
    port_req_valid = 3'b111;
    repeat (6) tick();
    @(negedge clk);
    check("rr_saturated_valid", mem_req_valid, 0);
    @(posedge clk); #1;
    port_req_valid = '0;
    check("rr_grant_count", grant_tag.size() - gb, 6);
    for (int i = 0; i < 6; i++)
      if (grant_tag.size() > gb + i) check("rr_grant_order", grant_tag[gb+i], i % 3);

    // Routing: tag 1 beats then tag 0 beats reach only their ports.
    rs0 = resp_seen[0]; rs1 = resp_seen[1]; rs2 = resp_seen[2];
    send_resp(1, 4);
    send_resp(0, 4);
    check("route_port1_beats", resp_seen[1] - rs1, 4);
    check("route_port0_beats", resp_seen[0] - rs0, 4);
    check("route_port2_beats", resp_seen[2] - rs2, 0);
    send_resp(0, 4); send_resp(1, 4); send_resp(2, 8);

    // Outstanding limit on port 0.
    gb = grant_tag.size();
    port_req_addr[0 +: A] = 16'h1100;
    port_req_valid[0] = 1'b1;
    wait_req(0);
    wait_req(0);
    tick(); tick(); tick();
    @(negedge clk);
    check("limit_third_ready", port_req_ready[0], 0);
    @(posedge clk); #1;
    send_resp(0, 4);
    wait_req(0);
    port_req_valid[0] = 1'b0;
    check("limit_grant_count", grant_tag.size() - gb, 3);
    if (grant_cyc.size() > gb + 2) check("limit_issue_latency", grant_cyc[gb+2] - last_resp_cyc, 1);
    send_resp(0, 8);

    // Write lock: port 1 writes 4 beats while port 0 waits to read.
    gb = grant_tag.size();
    bb = beat_log.size();
    port_req_addr[A +: A] = 16'h2200;
    port_req_addr[0 +: A] = 16'h1200;
    port_req_rw = 3'b010;
    port_req_valid = 3'b011;
    port_req_data_valid[1] = 1'b1;
    set_wbeat(1, 0);
    wait_req(1);
    port_req_valid[1] = 1'b0; port_req_rw[1] = 1'b0;
    for (int b = 0; b < B; b++) begin
      wait_beat(1);
      if (b < B - 1) set_wbeat(1, b + 1);
    end
    port_req_data_valid[1] = 1'b0;
    wait_req(0);
    port_req_valid[0] = 1'b0;
    check("wlock_grant_count", grant_tag.size() - gb, 2);
    if (grant_tag.size() >= gb + 2) begin
      check("wlock_first_tag", grant_tag[gb], 1);
      check("wlock_second_tag", grant_tag[gb+1], 0);
      check("wlock_gap", grant_cyc[gb+1] - grant_cyc[gb], 5);
    end
    check("wlock_beat_count", beat_log.size() - bb, 4);
    for (int b = 0; b < B; b++) begin
      bv = 32'hBEEF_0000 + 32'(b);
      if (beat_log.size() > bb + b) check("wlock_beat", beat_log[bb+b], {mask_tab[b], bv});
    end
    send_resp(0, 4);

    // Bad tag 3 with three ports.
    mem_resp_valid = 1'b1; mem_resp_tag = 3'd3;
    @(negedge clk);
    check("badtag_resp_valid", port_resp_valid, 0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    tick(); tick(); tick();
    check("badtag_err_held", resp_tag_err, 1);

    // Reset in the middle of a port 2 write.
    port_req_addr[2*A +: A] = 16'h3300;
    port_req_rw[2] = 1'b1; port_req_valid[2] = 1'b1;
    port_req_data_valid[2] = 1'b1;
    set_wbeat(2, 0);
    wait_req(2);
    port_req_valid[2] = 1'b0; port_req_rw[2] = 1'b0;
    wait_beat(2);
    set_wbeat(2, 1);
    wait_beat(2);
    port_req_valid[1:0] = 2'b11;
    #2;
    reset_n = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_tag = 3'd0;
    #1;
    check("mrst_mem_req_valid", mem_req_valid, 0);
    check("mrst_port_req_ready", port_req_ready, 0);
    check("mrst_data_valid", mem_req_data_valid, 0);
    check("mrst_data_ready", port_req_data_ready, 0);
    check("mrst_resp_valid", port_resp_valid, 0);
    check("mrst_tag_err", resp_tag_err, 0);
    mem_resp_valid = 1'b0;
    port_req_data_valid[2] = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", mem_req_valid, 1);
    check("post_rst_tag", mem_req_tag, 0);
    check("post_rst_ready", port_req_ready, 3'b001);
    check("post_rst_data_valid", mem_req_data_valid, 0);
    @(posedge clk); #1;
    port_req_valid = '0;
    send_resp(0, 4);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_nport.md
# mem_arbiter_nport

N-port, round-robin arbiter between cache-side requesters (icache, dcache, and later DMA/prefetch ports) and the single main-memory interface. It generalises the fixed two-port icache/dcache arbiter. Features: parametrised port count, fair round-robin grant, write-data beat locking, tag-based response routing and per-port outstanding-read limits. It sits between the cache instances and the external memory model inside the memory subsystem wrapper.

## Interface
- N_PORTS, 2, number of requesters (2..8)
- MEM_ADDR_BITS, `MEM_ADDR_BITS, request address width
- MEM_DATA_BITS, `MEM_DATA_BITS, data beat width
- MEM_TAG_BITS, `MEM_TAG_BITS, memory tag width; must be ≥ clog2(N_PORTS)
- DATA_BEATS, `MEM_DATA_CYCLES, beats per line (write and read)
- MAX_OUTSTANDING, 2, reads in flight per port (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- port_req_valid / port_req_ready  in/out  N_PORTS  per-port request handshake
- port_req_rw  in  N_PORTS  1 = write
- port_req_addr  in  N_PORTS*MEM_ADDR_BITS  flattened; port i at [i*A +: A]
- port_req_data_valid / port_req_data_ready  in/out  N_PORTS  write-beat handshake
- port_req_data_bits  in  N_PORTS*MEM_DATA_BITS  flattened write data
- port_req_data_mask  in  N_PORTS*MEM_DATA_BITS/8  flattened byte mask
- port_resp_valid  out  N_PORTS  response beat for port i; data is mem_resp_data (broadcast)
- mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag  out  1/1/A/T  memory request
- mem_req_ready  in  1
- mem_req_data_valid, mem_req_data_bits, mem_req_data_mask  out  1/D/D/8
- mem_req_data_ready  in  1
- mem_resp_valid, mem_resp_tag  in  1/T
- resp_tag_err  out  1  sticky: response tag decoded to a port index ≥ N_PORTS

## Operation
- States: IDLE, WDATA.
- Port i is eligible in IDLE when both hold:
  - port_req_valid[i] is high.
  - Either port_req_rw[i] = 1, or outstanding[i] < MAX_OUTSTANDING.
- Grant: the first eligible port scanning from rr_ptr upward, modulo N_PORTS. The grant is combinational in IDLE.
- mem_req_valid = any eligible port, in IDLE only. rw and addr are muxed from the granted port.
- mem_req_tag = granted index, zero-extended to MEM_TAG_BITS.
- port_req_ready[g] = mem_req_ready for the granted port g only. All other ready outputs are 0.
- On request accept (mem_req_valid & mem_req_ready):
  - rr_ptr ← (g+1) mod N_PORTS.
  - Read: outstanding[g] += 1.
  - Write: wport ← g, beat_cnt ← 0, state → WDATA.
- WDATA:
  - mem_req_data_valid = port_req_data_valid[wport].
  - bits and mask are muxed from wport.
  - port_req_data_ready[wport] = mem_req_data_ready.
  - Each accepted beat increments beat_cnt. The beat with beat_cnt = DATA_BEATS-1 returns the block to IDLE.
  - No request is issued while in WDATA.
- Outside WDATA, all data_valid and data_ready outputs are 0.
- Responses:
  - port_resp_valid[i] = mem_resp_valid & (mem_resp_tag == i). This is combinational, with no added latency.
  - Per-port resp_cnt counts beats. The beat with resp_cnt = DATA_BEATS-1 wraps resp_cnt to 0 and decrements outstanding[i].
  - Read beats for one request arrive contiguously.
- Same-cycle issue and retire on one port: outstanding is unchanged.
- Bad tag (index ≥ N_PORTS): no port_resp_valid fires, no counter changes, and resp_tag_err sets until reset.
- Writes produce no response and do not use outstanding slots.

## Timing
- Reset (reset_n low, async) sets:
  - state = IDLE, rr_ptr = 0.
  - All outstanding, resp_cnt and beat_cnt = 0.
  - resp_tag_err = 0.
- While reset_n is low, all valid and ready outputs are forced to 0.
- Reset mid-WDATA abandons the write. The requester must re-issue it.
- Request path: zero-cycle combinational valid and ready; the grant is stable while valid is held.
- First write beat can be accepted the cycle after request accept. The minimum write is 1 + DATA_BEATS cycles.
- Outstanding width: clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING and never underflows. A response on a port with outstanding = 0 is ignored and sets resp_tag_err.

## Structure
- Shared package/header: state encoding (IDLE, WDATA) and a clog2 function.
- Sub-module rr_picker (N-bit request vector + pointer → one-hot grant + index) is natural. The rest stays flat.

## Test plan
- Round-robin fairness:
  - Stimulus: N_PORTS=3, all ports issue continuous reads, mem_req_ready=1, responses return promptly.
  - Required: grant order 0,1,2,0,1,2; tags 0,1,2 repeat.
- Write lock:
  - Stimulus: port 1 writes, DATA_BEATS=4; port 0 requests during the beats.
  - Required: port 0 is not granted until the cycle after the 4th beat accept. Beats reach memory in order with the correct mask.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING=2, port 0 issues 3 reads, memory withholds responses.
  - Required: the 3rd request stays not-ready. It issues the cycle after the 4th beat of the first response.
- Response routing:
  - Stimulus: tag=1 beats, then tag=0 beats.
  - Required: only port_resp_valid[1], then only [0], each asserted for exactly 4 cycles.
- Bad tag:
  - Stimulus: N_PORTS=3, response with tag 3.
  - Required: no port_resp_valid; resp_tag_err=1 and held.
- Reset mid-write:
  - Stimulus: drop reset_n after the 2nd beat.
  - Required: all outputs 0 immediately. After release: state IDLE, rr_ptr=0, and a fresh read from port 0 issues with tag 0.
